// File: rtl/loop_sequencer_if.sv
// Handshake bundle between loop_sequencer and the single-cycle datapath.
// The step input exists only when LOOP_SEQUENCER_STEP_EN is defined.
interface loop_sequencer_if #(
  parameter int SEL_W = 2,
  parameter int PC_W  = 12
);
  logic             start;
  logic             lt_flag;
`ifdef LOOP_SEQUENCER_STEP_EN
  logic             step;
`endif
  logic [SEL_W-1:0] i_sel;
  logic             exec;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [7:0]       iter_count;

`ifdef LOOP_SEQUENCER_STEP_EN
  modport master (input start, lt_flag, step,
                  output i_sel, exec, pc, busy, done, timeout, iter_count);
  modport slave  (output start, lt_flag, step,
                  input i_sel, exec, pc, busy, done, timeout, iter_count);
`else
  modport master (input start, lt_flag,
                  output i_sel, exec, pc, busy, done, timeout, iter_count);
  modport slave  (output start, lt_flag,
                  input i_sel, exec, pc, busy, done, timeout, iter_count);
`endif
endinterface

// File: rtl/loop_sequencer.sv
// Preamble + compare-driven loop sequencer with iteration watchdog.
// Optional single-step gating is enabled by defining LOOP_SEQUENCER_STEP_EN.
module loop_sequencer #(
  parameter int SEL_W    = 2,
  parameter int PC_W     = 12,
  parameter int PC_STEP  = 4,
  parameter int MAX_ITER = 255
) (
  input  logic                clock,
  input  logic                reset,
  loop_sequencer_if.master    bus
);
  typedef enum logic [2:0] {IDLE, PRE0, PRE1, CHECK, BODY0, BODY1, DONE} state_e;

  localparam logic [7:0] MAX_I = 8'(MAX_ITER);

  state_e           state_q, state_d;
  logic [7:0]       iter_q;
  logic [7:0]       iter_inc;
  logic             timeout_q;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             exec_q, exec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hold;

`ifdef LOOP_SEQUENCER_STEP_EN
  assign hold = (state_q inside {PRE0, PRE1, CHECK, BODY0, BODY1}) && !bus.step;
`else
  assign hold = 1'b0;
`endif

  assign iter_inc = iter_q + 8'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        IDLE:    if (bus.start) state_d = PRE0;
        PRE0:    state_d = PRE1;
        PRE1:    state_d = CHECK;
        CHECK:   state_d = bus.lt_flag ? BODY0 : DONE;
        BODY0:   state_d = BODY1;
        BODY1:   state_d = (iter_inc == MAX_I) ? DONE : CHECK;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    sel_d  = '0;
    exec_d = 1'b0;
    pc_d   = '0;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      IDLE:  busy_d = 1'b0;
      PRE0:  exec_d = 1'b1;
      PRE1:  begin sel_d = SEL_W'(1); exec_d = 1'b1; pc_d = PC_W'(PC_STEP); end
      CHECK: pc_d = PC_W'(2 * PC_STEP);
      BODY0: begin sel_d = SEL_W'(2); exec_d = 1'b1; pc_d = PC_W'(2 * PC_STEP); end
      BODY1: begin sel_d = SEL_W'(3); exec_d = 1'b1; pc_d = PC_W'(3 * PC_STEP); end
      DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
    // A held slot keeps its address but must not write back a second time.
    if (hold) exec_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_q  <= '0;
      exec_q <= 1'b0;
      pc_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      exec_q <= exec_d;
      pc_q   <= pc_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == IDLE && state_d == PRE0) begin
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == BODY1 && !hold) begin
      iter_q <= iter_inc;
      if (iter_inc == MAX_I) timeout_q <= 1'b1;
    end
  end

  assign bus.i_sel      = sel_q;
  assign bus.exec       = exec_q;
  assign bus.pc         = pc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_loop_sequencer.sv
// Scoreboard bench for loop_sequencer: directed runs push the expected per-cycle
// trace, a monitor pops one record for every cycle the sequencer is busy.
module tb_loop_sequencer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  loop_sequencer_if #(.SEL_W(2), .PC_W(12)) bus ();

  loop_sequencer #(.SEL_W(2), .PC_W(12), .PC_STEP(4), .MAX_ITER(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Datapath model: 0: r1=a0, 1: r2=b0, 2: r1++, 3: r3++ ; lt = r1 < r2
  logic [7:0] a0, b0, r1, r2, r3;
  logic       force_lt;
  always @(posedge clock) begin
    if (bus.exec) begin
      case (bus.i_sel)
        2'd0: r1 <= a0;
        2'd1: r2 <= b0;
        2'd2: r1 <= r1 + 8'd1;
        default: r3 <= r3 + 8'd1;
      endcase
    end
  end
  assign bus.lt_flag = force_lt | (r1 < r2);

  typedef struct packed {
    logic [1:0]  sel;
    logic        ex;
    logic [11:0] pc;
    logic        dn;
    logic        to;
    logic [7:0]  it;
    logic        chka;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  logic mon_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    else n_pass++;
  endtask

  function automatic void push(input logic [1:0] sel, input logic ex, input logic [11:0] pc,
                               input logic dn, input logic to, input logic [7:0] it,
                               input logic chka);
    exp_t e;
    e = '{sel: sel, ex: ex, pc: pc, dn: dn, to: to, it: it, chka: chka};
    exp_q.push_back(e);
  endfunction

  // Expected trace for a run of n iterations; with to=1 the watchdog ends it.
  function automatic void build(input int n, input logic to);
    push(2'd0, 1'b1, 12'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    push(2'd1, 1'b1, 12'd4, 1'b0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < n; i++) begin
      push(2'd0, 1'b0, 12'd8,  1'b0, 1'b0, 8'(i), 1'b1);
      push(2'd2, 1'b1, 12'd8,  1'b0, 1'b0, 8'(i), 1'b1);
      push(2'd3, 1'b1, 12'd12, 1'b0, 1'b0, 8'(i), 1'b1);
    end
    if (!to) push(2'd0, 1'b0, 12'd8, 1'b0, 1'b0, 8'(n), 1'b1);
    push(2'd0, 1'b0, 12'd0, 1'b1, to, 8'(n), 1'b0);
  endfunction

  always @(negedge clock) begin
    if (mon_en && reset && bus.busy) begin
      if (exp_q.size() == 0) chk("unexpected_busy_cycle", 32'(bus.pc), 32'hFFFF_FFFF);
      else begin
        mon_e = exp_q.pop_front();
        chk("trace",
            32'({(mon_e.chka ? bus.i_sel : mon_e.sel), bus.exec,
                 (mon_e.chka ? bus.pc : mon_e.pc), bus.done, bus.timeout, bus.iter_count}),
            32'({mon_e.sel, mon_e.ex, mon_e.pc, mon_e.dn, mon_e.to, mon_e.it}));
      end
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // One full run; pokes start during the first BODY1 (if ign) and during DONE.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic flt,
                     input int n, input logic to, input logic ign);
    int  cyc;
    logic poked;
    a0 = a; b0 = b; force_lt = flt;
    build(n, to);
    @(negedge clock);
    pulse_start();
    cyc = 0; poked = 1'b0;
    while (!bus.done && cyc < 100) begin
      bus.start = ign && !poked && bus.exec && bus.i_sel == 2'd3;
      if (bus.start) poked = 1'b1;
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) chk("done_within_budget", 32'(cyc), 32'd0);
    pulse_start();
    chk("idle_after_done", 32'({bus.busy, bus.exec, bus.done}), 32'd0);
    chk("iter_count_hold", 32'(bus.iter_count), 32'(n));
    chk("timeout_hold", 32'(bus.timeout), 32'(to));
    chk("trace_drained", 32'(exp_q.size()), 32'd0);
    force_lt = 1'b0;
  endtask

  initial begin
    int cnt, cyc;
    reset = 1'b0; bus.start = 1'b1; force_lt = 1'b0; a0 = 8'd0; b0 = 8'd0;
`ifdef LOOP_SEQUENCER_STEP_EN
    bus.step = 1'b1;
`endif
    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'({bus.i_sel, bus.exec, bus.pc, bus.busy, bus.done,
                             bus.timeout, bus.iter_count}), 32'd0);
    reset = 1'b1; bus.start = 1'b0;
    repeat (3) @(negedge clock);
    chk("no_exec_without_start", 32'({bus.exec, bus.busy}), 32'd0);

    run(8'd0, 8'd3, 1'b0, 3, 1'b0, 1'b1);   // three iterations, start pokes ignored
    run(8'd5, 8'd2, 1'b0, 0, 1'b0, 1'b0);   // zero iterations
    run(8'd0, 8'd0, 1'b1, 4, 1'b1, 1'b0);   // watchdog at MAX_ITER=4
    run(8'd5, 8'd2, 1'b0, 0, 1'b0, 1'b0);   // next start clears timeout

    // Reset during BODY0 of the second iteration.
    mon_en = 1'b0; a0 = 8'd0; b0 = 8'd3;
    pulse_start();
    cnt = 0; cyc = 0;
    while (cnt < 2 && cyc < 100) begin
      if (bus.exec && bus.i_sel == 2'd2) cnt++;
      if (cnt < 2) begin @(negedge clock); cyc++; end
    end
    chk("abort_reached_body0", 32'(cnt), 32'd2);
    reset = 1'b0;
    #1;
    chk("abort_outputs", 32'({bus.i_sel, bus.exec, bus.pc, bus.busy, bus.done,
                             bus.timeout, bus.iter_count}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_no_done", 32'({bus.done, bus.busy}), 32'd0);
    end
    reset = 1'b1;
    mon_en = 1'b1;
    run(8'd1, 8'd3, 1'b0, 2, 1'b0, 1'b0);

`ifdef LOOP_SEQUENCER_STEP_EN
    mon_en = 1'b0; a0 = 8'd0; b0 = 8'd3;
    pulse_start();
    cyc = 0;
    while (!(bus.exec && bus.i_sel == 2'd2) && cyc < 100) begin @(negedge clock); cyc++; end
    bus.step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("step_hold", 32'({bus.i_sel, bus.exec, bus.pc, bus.iter_count}),
          32'({2'd2, 1'b0, 12'd8, 8'd0}));
    end
    bus.step = 1'b1;
    @(negedge clock);
    chk("step_advance", 32'({bus.i_sel, bus.exec, bus.pc}), 32'({2'd3, 1'b1, 12'd12}));
    cyc = 0;
    while (!bus.done && cyc < 100) begin @(negedge clock); cyc++; end
    chk("step_run_done", 32'({bus.done, bus.iter_count}), 32'({1'b1, 8'd3}));
    @(negedge clock);
    mon_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
